// File: rtl/queue_2x122_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : queue_2x122_ctrl_if
//  Description : Enqueue/dequeue handshake bundle for queue_2x122_ctrl.
//                Carries the ready/valid enqueue channel, the ready/valid
//                dequeue channel and the occupancy count.
//                  master : producer/consumer side (drives enq_valid/bits,
//                           deq_ready)
//                  slave  : queue side (drives enq_ready, deq_valid/bits,
//                           count)
//  Parameters  : WIDTH (payload bits), DEPTH (entries)
//  Revision    : 1.0 - initial release
// ============================================================================
interface queue_2x122_ctrl_if #(
    parameter int WIDTH = 122,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_valid;
    logic             io_deq_ready;
    logic [WIDTH-1:0] io_deq_bits;
    logic [CNT_W-1:0] io_count;

    modport master (
        output io_enq_valid,
        output io_enq_bits,
        output io_deq_ready,
        input  io_enq_ready,
        input  io_deq_valid,
        input  io_deq_bits,
        input  io_count
    );

    modport slave (
        input  io_enq_valid,
        input  io_enq_bits,
        input  io_deq_ready,
        output io_enq_ready,
        output io_deq_valid,
        output io_deq_bits,
        output io_count
    );
endinterface
`default_nettype wire

// File: rtl/queue_2x122_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : queue_2x122_ctrl
//  Description : Ready/valid FIFO control stage for the 2 x 122-bit queue
//                storage macro (ram_2x122). Owns the enqueue/dequeue
//                pointers and the full/empty tracking, writes accepted words
//                into the macro and presents the macro's combinational read
//                data as the dequeue head.
//  Ports       : clock        - sole clock, forwarded to the macro clocks
//                reset        - asynchronous active-low reset
//                io           - handshake bundle (slave modport)
//                ram_R0_*     - macro read port (addr = deq pointer)
//                ram_W0_*     - macro write port (addr = enq pointer)
//  Options     : QUEUE_FLOW_EN - when defined, an enqueue into an empty
//                queue is visible on the dequeue side in the same cycle, and
//                is consumed without touching the macro if deq_ready is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_2x122_ctrl #(
    parameter  int WIDTH  = 122,
    parameter  int DEPTH  = 2,
    localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic              clock,
    input  wire logic              reset,
    queue_2x122_ctrl_if.slave      io,
    output logic [ADDR_W-1:0]      ram_R0_addr,
    output logic                   ram_R0_en,
    output logic                   ram_R0_clk,
    input  wire logic [WIDTH-1:0]  ram_R0_data,
    output logic [ADDR_W-1:0]      ram_W0_addr,
    output logic                   ram_W0_en,
    output logic                   ram_W0_clk,
    output logic [WIDTH-1:0]       ram_W0_data
);

    // Last valid pointer value; pointers wrap on an explicit compare so a
    // non-power-of-two DEPTH never visits unused addresses.
    localparam logic [ADDR_W-1:0] c_LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_DEPTH_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_enq_ptr;
    logic [ADDR_W-1:0] r_deq_ptr;
    logic              r_maybe_full;

    // ------------------------------------------------------------------
    // Derived status
    // ------------------------------------------------------------------
    logic w_ptr_match;
    logic w_empty;
    logic w_full;
    logic w_enq_ready;
    logic w_deq_valid;
    logic w_do_enq;
    logic w_do_deq;
    logic [WIDTH-1:0] w_deq_bits;
    logic [CNT_W-1:0] w_count;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match &  r_maybe_full;
    assign w_enq_ready = ~w_full;

`ifdef QUEUE_FLOW_EN
    // Flow-through: an arriving word on an empty queue is offered to the
    // consumer directly. If taken in the same cycle, the storage and the
    // pointers are left untouched, as though the word never entered.
    logic w_flow;
    assign w_flow      = w_empty & io.io_enq_valid;
    assign w_deq_valid = ~w_empty | w_flow;
    assign w_deq_bits  = w_flow ? io.io_enq_bits : ram_R0_data;
    assign w_do_enq    = io.io_enq_valid & w_enq_ready
                       & ~(w_flow & io.io_deq_ready);
    assign w_do_deq    = w_deq_valid & io.io_deq_ready & ~w_flow;
`else
    assign w_deq_valid = ~w_empty;
    assign w_deq_bits  = ram_R0_data;
    assign w_do_enq    = io.io_enq_valid & w_enq_ready;
    assign w_do_deq    = w_deq_valid & io.io_deq_ready;
`endif

    // ------------------------------------------------------------------
    // Pointer / fullness registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_do_enq) begin
                r_enq_ptr <= (r_enq_ptr == c_LAST_PTR) ? '0
                                                       : r_enq_ptr + 1'b1;
            end
            if (w_do_deq) begin
                r_deq_ptr <= (r_deq_ptr == c_LAST_PTR) ? '0
                                                       : r_deq_ptr + 1'b1;
            end
            // Equal pointers are ambiguous; remember which side moved last.
            if (w_do_enq != w_do_deq) begin
                r_maybe_full <= w_do_enq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: modular pointer distance, disambiguated by maybe_full
    // when the pointers coincide.
    // ------------------------------------------------------------------
    always_comb begin
        w_count = '0;
        if (w_ptr_match) begin
            w_count = w_full ? c_DEPTH_CNT : '0;
        end else if (r_enq_ptr > r_deq_ptr) begin
            w_count = CNT_W'(r_enq_ptr) - CNT_W'(r_deq_ptr);
        end else begin
            w_count = c_DEPTH_CNT + CNT_W'(r_enq_ptr) - CNT_W'(r_deq_ptr);
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    assign io.io_enq_ready = w_enq_ready;
    assign io.io_deq_valid = w_deq_valid;
    assign io.io_deq_bits  = w_deq_bits;
    assign io.io_count     = w_count;

    // ------------------------------------------------------------------
    // Macro ports. The read is always enabled; a read and write to the
    // same live address cannot coincide, so macro read-during-write
    // ordering never matters.
    // ------------------------------------------------------------------
    assign ram_R0_addr = r_deq_ptr;
    assign ram_R0_en   = 1'b1;
    assign ram_R0_clk  = clock;
    assign ram_W0_addr = r_enq_ptr;
    assign ram_W0_en   = w_do_enq;
    assign ram_W0_clk  = clock;
    assign ram_W0_data = io.io_enq_bits;

endmodule
`default_nettype wire

// File: tb/tb_queue_2x122_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_2x122_ctrl
//  Description : Directed bench for queue_2x122_ctrl. A DEPTH=2/WIDTH=122
//                instance and a DEPTH=3/WIDTH=8 instance, each with a
//                behavioural storage model (synchronous write, combinational
//                read) standing in for the macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_2x122_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DEPTH=2, WIDTH=122 ----------------
    queue_2x122_ctrl_if #(.WIDTH(122), .DEPTH(2)) q_if ();
    logic [0:0]   r0_addr, w0_addr;
    logic         r0_en, r0_clk, w0_en, w0_clk;
    logic [121:0] r0_data, w0_data;
    logic [121:0] mem2 [2];

    queue_2x122_ctrl #(.WIDTH(122), .DEPTH(2)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .io          (q_if),
        .ram_R0_addr (r0_addr),
        .ram_R0_en   (r0_en),
        .ram_R0_clk  (r0_clk),
        .ram_R0_data (r0_data),
        .ram_W0_addr (w0_addr),
        .ram_W0_en   (w0_en),
        .ram_W0_clk  (w0_clk),
        .ram_W0_data (w0_data)
    );

    always @(posedge w0_clk) if (w0_en) mem2[w0_addr] <= w0_data;
    assign r0_data = mem2[r0_addr];

    // ---------------- DEPTH=3, WIDTH=8 ----------------
    queue_2x122_ctrl_if #(.WIDTH(8), .DEPTH(3)) q3_if ();
    logic [1:0] r3_addr, w3_addr;
    logic       r3_en, r3_clk, w3_en, w3_clk;
    logic [7:0] r3_data, w3_data;
    logic [7:0] mem3 [3];

    queue_2x122_ctrl #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clock       (clk),
        .reset       (rst_n),
        .io          (q3_if),
        .ram_R0_addr (r3_addr),
        .ram_R0_en   (r3_en),
        .ram_R0_clk  (r3_clk),
        .ram_R0_data (r3_data),
        .ram_W0_addr (w3_addr),
        .ram_W0_en   (w3_en),
        .ram_W0_clk  (w3_clk),
        .ram_W0_data (w3_data)
    );

    always @(posedge w3_clk) if (w3_en) mem3[w3_addr] <= w3_data;
    assign r3_data = (r3_addr < 2'd3) ? mem3[r3_addr] : 8'hxx;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen
    // mid-cycle, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [121:0] b, input logic r);
        q_if.io_enq_valid = v;
        q_if.io_enq_bits  = b;
        q_if.io_deq_ready = r;
        #1;
    endtask

    task automatic drive3(input logic v, input logic [7:0] b, input logic r);
        q3_if.io_enq_valid = v;
        q3_if.io_enq_bits  = b;
        q3_if.io_deq_ready = r;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        q_if.io_enq_valid  = 1'b0;
        q_if.io_enq_bits   = '0;
        q_if.io_deq_ready  = 1'b0;
        q3_if.io_enq_valid = 1'b0;
        q3_if.io_enq_bits  = '0;
        q3_if.io_deq_ready = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_enq_ready", q_if.io_enq_ready, 1);
        check("rst_deq_valid", q_if.io_deq_valid, 0);
        check("rst_count",     q_if.io_count,     0);
        check("rst_w0_en",     w0_en,             0);
        check("rst_r0_en",     r0_en,             1);
        #2 rst_n = 1'b1;
        step();

        // ---------------- fill / drain ----------------
        drive(1, 122'h1, 0);
        check("fill_w0_en",   w0_en,   1);
        check("fill_w0_addr", w0_addr, 0);
        step();
        check("fill_cnt1",    q_if.io_count,     1);
        check("fill_valid1",  q_if.io_deq_valid, 1);
        check("fill_head1",   q_if.io_deq_bits,  122'h1);
        drive(1, 122'h2, 0);
        check("fill_w0_addr2", w0_addr, 1);
        step();
        check("fill_cnt2",    q_if.io_count,     2);
        check("fill_full",    q_if.io_enq_ready, 0);
        drive(0, 122'h0, 1);
        check("drain_head1",  q_if.io_deq_bits,  122'h1);
        step();
        check("drain_head2",  q_if.io_deq_bits,  122'h2);
        check("drain_cnt1",   q_if.io_count,     1);
        step();
        check("drain_empty",  q_if.io_deq_valid, 0);
        check("drain_cnt0",   q_if.io_count,     0);

        // ---------------- full with simultaneous attempt ----------------
        drive(1, 122'hA, 0); step();
        drive(1, 122'hB, 0); step();
        check("full_cnt2",    q_if.io_count, 2);
        drive(1, 122'hC, 1);
        check("full_no_ready", q_if.io_enq_ready, 0);
        check("full_no_write", w0_en,             0);
        check("full_headA",    q_if.io_deq_bits,  122'hA);
        step();
        check("full_cnt_after", q_if.io_count,    1);
        check("full_headB",     q_if.io_deq_bits, 122'hB);
        drive(1, 122'hC, 0);
        check("full_ready_again", q_if.io_enq_ready, 1);
        step();
        check("full_cnt_C",   q_if.io_count, 2);
        drive(0, 122'h0, 1);
        check("full_drainB",  q_if.io_deq_bits, 122'hB);
        step();
        check("full_drainC",  q_if.io_deq_bits, 122'hC);
        step();
        check("full_drained", q_if.io_count, 0);

        // ---------------- streaming, one resident entry ----------------
        drive(1, 122'h10, 0); step();
        for (int i = 1; i < 8; i++) begin
            drive(1, 122'(8'h10 + i), 1);
            check("stream_head",  q_if.io_deq_bits, 122'(8'h10 + i - 1));
            check("stream_count", q_if.io_count,    1);
            step();
        end
        drive(0, 122'h0, 1);
        check("stream_last", q_if.io_deq_bits, 122'h17);
        step();
        check("stream_empty", q_if.io_count, 0);

        // ---------------- empty with enq and deq_ready ----------------
        drive(1, 122'h3FF, 1);
`ifdef QUEUE_FLOW_EN
        check("flow_valid", q_if.io_deq_valid, 1);
        check("flow_bits",  q_if.io_deq_bits,  122'h3FF);
        check("flow_w0_en", w0_en,             0);
        check("flow_count", q_if.io_count,     0);
        step();
        drive(0, 122'h0, 0);
        check("flow_after_cnt",   q_if.io_count,     0);
        check("flow_after_valid", q_if.io_deq_valid, 0);
`else
        check("noflow_valid", q_if.io_deq_valid, 0);
        check("noflow_w0_en", w0_en,             1);
        step();
        drive(0, 122'h0, 1);
        check("noflow_next_valid", q_if.io_deq_valid, 1);
        check("noflow_next_bits",  q_if.io_deq_bits,  122'h3FF);
        check("noflow_next_cnt",   q_if.io_count,     1);
        step();
        drive(0, 122'h0, 0);
        check("noflow_drained", q_if.io_count, 0);
`endif

        // ---------------- reset mid-stream ----------------
        drive(1, 122'h55, 0); step();
        check("mrst_pre_cnt", q_if.io_count, 1);
        drive(0, 122'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_enq_ready", q_if.io_enq_ready, 1);
        check("mrst_deq_valid", q_if.io_deq_valid, 0);
        check("mrst_count",     q_if.io_count,     0);
        step();
        #2 rst_n = 1'b1;
        step();
        drive(1, 122'h66, 0); step();
        drive(0, 122'h0, 1);
        check("mrst_first_word", q_if.io_deq_bits, 122'h66);
        check("mrst_first_cnt",  q_if.io_count,    1);
        step();
        drive(0, 122'h0, 0);
        check("mrst_drained", q_if.io_count, 0);

        // ---------------- DEPTH=3 instance ----------------
        drive3(1, 8'd1, 0); step();
        drive3(1, 8'd2, 0); step();
        drive3(1, 8'd3, 0);
        check("d3_w_addr2", w3_addr, 2);
        step();
        check("d3_cnt3",   q3_if.io_count,     3);
        check("d3_full",   q3_if.io_enq_ready, 0);
        drive3(0, 8'd0, 1);
        check("d3_head1",  q3_if.io_deq_bits, 8'd1);
        step();
        check("d3_cnt2",   q3_if.io_count, 2);
        drive3(1, 8'd4, 0);
        check("d3_enq_wrap", w3_addr, 0);
        step();
        check("d3_cnt3b",  q3_if.io_count, 3);
        drive3(0, 8'd0, 1);
        check("d3_head2",  q3_if.io_deq_bits, 8'd2);
        step();
        check("d3_head3",  q3_if.io_deq_bits, 8'd3);
        check("d3_r_addr2", r3_addr, 2);
        step();
        check("d3_deq_wrap", r3_addr, 0);
        check("d3_head4",    q3_if.io_deq_bits, 8'd4);
        check("d3_cnt1",     q3_if.io_count,    1);
        drive3(1, 8'd5, 1);
        step();
        check("d3_cnt1b",    q3_if.io_count,    1);
        check("d3_head5",    q3_if.io_deq_bits, 8'd5);
        drive3(0, 8'd0, 1);
        step();
        check("d3_empty",    q3_if.io_deq_valid, 0);
        check("d3_cnt0",     q3_if.io_count,     0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
